// File: rtl/adc_pkg.sv
// Shared definitions for the ADC SPI reader: FSM states and frame geometry.
package adc_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD,
    DONE
  } state_t;

  // One conversion frame is 16 SCLK periods: 4 leading zeros then 12 data bits.
  localparam int FRAME_BITS = 16;
  localparam int LEAD_ZEROS = 4;
  localparam int DATA_W     = 12;
  localparam int PERIOD_W   = $clog2(FRAME_BITS);

endpackage

// File: rtl/spi_clk_gen.sv
// SCLK generator for the ADC frame. A start strobe launches 16 SCLK periods,
// each CLK_DIV cycles low then CLK_DIV cycles high. SCLK idles high and stays
// high after the final period. Strobes are valid in the cycle before the edge
// they describe, so the caller can act on the same clk edge that moves SCLK.
module spi_clk_gen
  import adc_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  output logic                sclk,
  output logic                rise,
  output logic                high_end,
  output logic [PERIOD_W-1:0] period
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic             active;
  logic [DIV_W-1:0] div;
  logic             half_end;
  logic             last;

  assign half_end = active && (div == DIV_W'(CLK_DIV - 1));
  assign rise     = half_end && !sclk;
  assign high_end = half_end && sclk;
  assign last     = high_end && (period == PERIOD_W'(FRAME_BITS - 1));

  // Half-period counter and SCLK toggling; the last high half is held so the
  // line stays high into the hold phase.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active <= 1'b0;
      sclk   <= 1'b1;
      div    <= '0;
      period <= '0;
    end else if (start) begin
      active <= 1'b1;
      sclk   <= 1'b0;
      div    <= '0;
      period <= '0;
    end else if (active) begin
      if (half_end) begin
        div <= '0;
        if (!sclk) begin
          sclk <= 1'b1;
        end else if (last) begin
          active <= 1'b0;
        end else begin
          sclk   <= 1'b0;
          period <= period + 1'b1;
        end
      end else begin
        div <= div + 1'b1;
      end
    end
  end

endmodule

// File: rtl/adc_spi_reader.sv
// SPI master for an AD7476-class 12-bit ADC. Starts one conversion per sample
// period, deserialises the 16-bit frame and presents the 12-bit result with a
// one-cycle valid strobe.
// Build option: define ADC_LEADING_ZERO_CHECK_EN to reject frames whose four
// leading bits are not zero (sample dropped, sticky frame_err set).
module adc_spi_reader
  import adc_pkg::*;
#(
  parameter int CLK_DIV       = 4,
  parameter int SAMPLE_PERIOD = 6250,
  parameter int QUIET         = 8,
  parameter int DATA_W        = adc_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              adc_sdata,
  output logic              adc_cs_n,
  output logic              adc_sclk,
  output logic [DATA_W-1:0] adc_data,
  output logic              sample_valid,
  output logic              frame_err
);

  localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int PCNT_W = $clog2(SAMPLE_PERIOD);
  localparam int Q_W    = $clog2(QUIET + 1);
`ifdef ADC_LEADING_ZERO_CHECK_EN
  localparam int SHIFT_W = FRAME_BITS;
`else
  // Without the check only the data bits are kept; leading bits shift out.
  localparam int SHIFT_W = DATA_W;
`endif

  if (CLK_DIV < 2) begin : g_bad_clk_div
    $error("adc_spi_reader: CLK_DIV must be at least 2");
  end
  if (SAMPLE_PERIOD < 34 * CLK_DIV + QUIET + 1) begin : g_bad_period
    $error("adc_spi_reader: SAMPLE_PERIOD too short for one frame plus quiet time");
  end
  if (DATA_W != FRAME_BITS - LEAD_ZEROS) begin : g_bad_data_w
    $error("adc_spi_reader: DATA_W must equal frame bits minus leading zeros");
  end

  state_t                state;
  logic [DIV_W-1:0]      cnt;
  logic [PCNT_W-1:0]     pcnt;
  logic [Q_W-1:0]        quiet_cnt;
  logic [SHIFT_W-1:0]    shift;
  logic                  tick;
  logic                  quiet_ok;
  logic                  gen_start;
  logic                  rise;
  logic                  high_end;
  logic [PERIOD_W-1:0]   period;
  logic                  shift_done;

  assign tick       = (pcnt == PCNT_W'(SAMPLE_PERIOD - 1));
  assign quiet_ok   = (quiet_cnt == Q_W'(QUIET));
  assign gen_start  = (state == SETUP) && (cnt == DIV_W'(CLK_DIV - 1));
  assign shift_done = high_end && (period == PERIOD_W'(FRAME_BITS - 1));

  spi_clk_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_clk_gen (
    .clk      (clk),
    .rst      (rst),
    .start    (gen_start),
    .sclk     (adc_sclk),
    .rise     (rise),
    .high_end (high_end),
    .period   (period)
  );

  // Free-running sample-period counter; tick marks its last count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pcnt <= '0;
    end else if (tick) begin
      pcnt <= '0;
    end else begin
      pcnt <= pcnt + 1'b1;
    end
  end

  // Counts cs_n-high cycles since the last frame, saturating at QUIET.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      quiet_cnt <= '0;
    end else if (state == SETUP || state == SHIFT || state == HOLD) begin
      quiet_cnt <= '0;
    end else if (!quiet_ok) begin
      quiet_cnt <= quiet_cnt + 1'b1;
    end
  end

  // Deserialiser: capture adc_sdata on each SCLK rising edge, MSB first.
  always_ff @(posedge clk) begin
    if (rise) begin
      shift <= {shift[SHIFT_W-2:0], adc_sdata};
    end
  end

`ifdef ADC_LEADING_ZERO_CHECK_EN
  logic frame_err_q;
  assign frame_err = frame_err_q;
`else
  assign frame_err = 1'b0;
`endif

  // Frame sequencer with registered chip select, sample and valid outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      adc_cs_n     <= 1'b1;
      adc_data     <= '0;
      sample_valid <= 1'b0;
`ifdef ADC_LEADING_ZERO_CHECK_EN
      frame_err_q  <= 1'b0;
`endif
    end else begin
      sample_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (tick && enable && quiet_ok) begin
            state    <= SETUP;
            cnt      <= '0;
            adc_cs_n <= 1'b0;
          end
        end
        SETUP: begin
          if (cnt == DIV_W'(CLK_DIV - 1)) begin
            cnt   <= '0;
            state <= SHIFT;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        SHIFT: begin
          if (shift_done) begin
            cnt   <= '0;
            state <= HOLD;
          end
        end
        HOLD: begin
          if (cnt == DIV_W'(CLK_DIV - 1)) begin
            cnt      <= '0;
            state    <= DONE;
            adc_cs_n <= 1'b1;
`ifdef ADC_LEADING_ZERO_CHECK_EN
            if (shift[SHIFT_W-1 -: LEAD_ZEROS] != '0) begin
              frame_err_q <= 1'b1;
            end else begin
              adc_data     <= shift[DATA_W-1:0];
              sample_valid <= 1'b1;
            end
`else
            adc_data     <= shift[DATA_W-1:0];
            sample_valid <= 1'b1;
`endif
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state    <= IDLE;
          adc_cs_n <= 1'b1;
        end
      endcase
    end
  end

endmodule
